// File: rtl/amiga_cp.sv
// rtl/amiga_cp.sv - clockport bus master running 68000-style S0..S7 I/O cycles with wait states
// Optional AMIGA_CP_REQ_LEVEL_EN: level-sensitive request with back-to-back cycles.
module amiga_cp #(
    parameter int WS_LOW_RD  = 0,
    parameter int WS_LOW_WR  = 1,
    parameter int WS_HIGH_RD = 3,
    parameter int WS_HIGH_WR = 4
) (
    input  logic       clk,
    input  logic       RESET_n,
    inout  wire  [7:0] D,
    input  logic [7:0] D_write,
    output logic [7:0] D_read,
    output logic [1:0] A,
    input  logic [1:0] A_val,
    output logic       CS_n,
    input  logic       INT6_n,
    output logic       INT6_sync_n,
    output logic       IOWR_n,
    output logic       IORD_n,
    input  logic       wait_states,
    input  logic       RnW,
    input  logic       request
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_W, ST_S5, ST_S6, ST_S7
    } state_t;

    state_t     r_state;
    logic       r_req_d;
    logic       r_rnw;
    logic       r_ws;
    logic [7:0] r_wcnt;
    logic [7:0] r_d_out;
    logic       r_d_oe;
    logic       r_int6_meta;
    logic [7:0] w_n;
    logic       w_start;

    assign D = r_d_oe ? r_d_out : 8'bz;

    always_comb begin
        w_n = '0;
        if (r_rnw) w_n = r_ws ? 8'(WS_HIGH_RD) : 8'(WS_LOW_RD);
        else       w_n = r_ws ? 8'(WS_HIGH_WR) : 8'(WS_LOW_WR);
    end

`ifdef AMIGA_CP_REQ_LEVEL_EN
    assign w_start = request;
`else
    assign w_start = request & ~r_req_d;
`endif

    // Outputs are registered: each transition sets the values seen during the state being entered.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state     <= ST_IDLE;
            r_req_d     <= 1'b0;
            r_rnw       <= 1'b1;
            r_ws        <= 1'b0;
            r_wcnt      <= '0;
            r_d_out     <= '0;
            r_d_oe      <= 1'b0;
            r_int6_meta <= 1'b1;
            INT6_sync_n <= 1'b1;
            D_read      <= '0;
            A           <= '0;
            CS_n        <= 1'b1;
            IORD_n      <= 1'b1;
            IOWR_n      <= 1'b1;
        end else begin
            r_req_d     <= request;
            r_int6_meta <= INT6_n;
            INT6_sync_n <= r_int6_meta;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_S0;
                        r_rnw   <= RnW;
                        r_ws    <= wait_states;
                        A       <= A_val;
                    end
                end
                ST_S0: r_state <= ST_S1;
                ST_S1: begin
                    r_state <= ST_S2;
                    CS_n    <= 1'b0;
                    if (r_rnw) begin
                        IORD_n <= 1'b0;
                    end else begin
                        r_d_out <= D_write;
                        r_d_oe  <= 1'b1;
                    end
                end
                ST_S2: begin
                    r_state <= ST_S3;
                    if (!r_rnw) IOWR_n <= 1'b0;
                end
                ST_S3: r_state <= ST_S4;
                ST_S4: begin
                    if (w_n == 8'd0) begin
                        r_state <= ST_S5;
                    end else begin
                        r_wcnt  <= w_n - 8'd1;
                        r_state <= ST_W;
                    end
                end
                ST_W: begin
                    if (r_wcnt == 8'd0) r_state <= ST_S5;
                    else                r_wcnt  <= r_wcnt - 8'd1;
                end
                ST_S5: r_state <= ST_S6;
                ST_S6: begin
                    r_state <= ST_S7;
                    CS_n    <= 1'b1;
                    IORD_n  <= 1'b1;
                    IOWR_n  <= 1'b1;
                    if (r_rnw) D_read <= D;
                end
                ST_S7: begin
                    r_d_oe <= 1'b0;
`ifdef AMIGA_CP_REQ_LEVEL_EN
                    if (request) begin
                        r_state <= ST_S0;
                        r_rnw   <= RnW;
                        r_ws    <= wait_states;
                        A       <= A_val;
                    end else begin
                        r_state <= ST_IDLE;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amiga_cp.sv
// tb/tb_amiga_cp.sv - randomized self-checking bench for amiga_cp against a cycle-timeline model
module tb_amiga_cp;

    logic       clk = 1'b0;
    logic       RESET_n;
    wire  [7:0] D;
    logic [7:0] D_write;
    logic [7:0] D_read;
    logic [1:0] A;
    logic [1:0] A_val;
    logic       CS_n;
    logic       INT6_n;
    logic       INT6_sync_n;
    logic       IOWR_n;
    logic       IORD_n;
    logic       wait_states;
    logic       RnW;
    logic       request;

    logic       per_oe;
    logic [7:0] per_data;

    int n_checks = 0;
    int n_errors = 0;

    assign D = per_oe ? per_data : 8'bz;

    always #5 clk = ~clk;

    amiga_cp dut (
        .clk(clk), .RESET_n(RESET_n), .D(D), .D_write(D_write), .D_read(D_read),
        .A(A), .A_val(A_val), .CS_n(CS_n), .INT6_n(INT6_n), .INT6_sync_n(INT6_sync_n),
        .IOWR_n(IOWR_n), .IORD_n(IORD_n), .wait_states(wait_states), .RnW(RnW),
        .request(request)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cycle_len(input bit rnw, input bit ws);
        int n;
        if (rnw) n = ws ? 3 : 0;
        else     n = ws ? 4 : 1;
        return 8 + n;
    endfunction

    // Clock k counts from S0 (k=0); a cycle of length L spans k=0..L-1.
    task automatic check_state(input int k, input int L, input bit rnw, input logic [1:0] a,
                               input logic [7:0] wd, input logic [7:0] pd);
        bit sel;
        bit wr_low;
        bit drv;
        sel    = (k >= 2) && (k <= L - 2);
        wr_low = !rnw && (k >= 3) && (k <= L - 2);
        drv    = !rnw && (k >= 2) && (k <= L - 1);
        chk($sformatf("CS_n@%0d", k), 32'(CS_n), sel ? 0 : 1);
        chk($sformatf("IORD_n@%0d", k), 32'(IORD_n), (rnw && sel) ? 0 : 1);
        chk($sformatf("IOWR_n@%0d", k), 32'(IOWR_n), wr_low ? 0 : 1);
        chk($sformatf("A@%0d", k), 32'(A), 32'(a));
        chk($sformatf("D@%0d", k), 32'(D), drv ? 32'(wd) : (rnw ? 32'(pd) : 32'h3C));
        if (rnw && k >= L - 1) chk($sformatf("D_read@%0d", k), 32'(D_read), 32'(pd));
    endtask

    task automatic run_cycle(input bit rnw, input bit ws, input logic [1:0] a,
                             input logic [7:0] wd, input logic [7:0] pd, input bit hold);
        int L;
        int last;
        L    = cycle_len(rnw, ws);
        last = hold ? 100 : L + 3;
        @(negedge clk);
        RnW         = rnw;
        wait_states = ws;
        A_val       = a;
        D_write     = rnw ? ~pd : wd;
        per_data    = rnw ? pd : 8'h3C;
        per_oe      = 1'b1;
        request     = 1'b1;
        for (int k = 0; k < last; k++) begin
            @(negedge clk);
            check_state(k, L, rnw, a, wd, pd);
            if (k == 0) begin
                RnW         = ~rnw;
                wait_states = ~ws;
                A_val       = ~a;
            end
            if (k == 2 && !rnw) D_write = ~wd;
            if (!rnw) per_oe = !((k + 1 >= 2) && (k + 1 <= L - 1));
            if (!hold && k == 1) request = 1'b0;
            if (hold && k == 3) request = 1'b0;
            if (hold && k == 5) request = 1'b1;
        end
        request = 1'b0;
        per_oe  = 1'b1;
    endtask

    initial begin
        RESET_n     = 1'b0;
        request     = 1'b1;
        RnW         = 1'b1;
        wait_states = 1'b0;
        A_val       = 2'd1;
        D_write     = 8'h88;
        INT6_n      = 1'b1;
        per_oe      = 1'b1;
        per_data    = 8'h77;
        repeat (3) @(negedge clk);
        chk("rst_CS_n", 32'(CS_n), 1);
        chk("rst_IORD_n", 32'(IORD_n), 1);
        chk("rst_IOWR_n", 32'(IOWR_n), 1);
        chk("rst_A", 32'(A), 0);
        chk("rst_D_read", 32'(D_read), 0);
        chk("rst_D", 32'(D), 32'h77);
        chk("rst_INT6", 32'(INT6_sync_n), 1);

        // Request already high when reset releases must still start one read.
        RESET_n = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            check_state(k, 8, 1'b1, 2'd1, 8'h00, 8'h77);
            if (k == 1) request = 1'b0;
        end

        INT6_n = 1'b0;
        @(negedge clk);
        chk("int6_1clk", 32'(INT6_sync_n), 1);
        @(negedge clk);
        chk("int6_2clk", 32'(INT6_sync_n), 0);
        INT6_n = 1'b1;

        run_cycle(1'b1, 1'b0, 2'd2, 8'h00, 8'h5A, 1'b0);
        run_cycle(1'b1, 1'b1, 2'd3, 8'h00, 8'hA6, 1'b0);
        run_cycle(1'b0, 1'b0, 2'd1, 8'hC3, 8'h00, 1'b0);
        run_cycle(1'b0, 1'b1, 2'd0, 8'h96, 8'h00, 1'b0);
        run_cycle(1'b1, 1'b0, 2'd1, 8'h00, 8'h42, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
                      8'($urandom_range(1, 254)), 1'b0);
        end

        // Reset during S4 of a write abandons the cycle immediately.
        @(negedge clk);
        RnW         = 1'b0;
        wait_states = 1'b0;
        A_val       = 2'd3;
        D_write     = 8'hE1;
        per_data    = 8'h3C;
        request     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_state(k, 9, 1'b0, 2'd3, 8'hE1, 8'h00);
            if (k == 1) request = 1'b0;
            per_oe = !((k + 1 >= 2) && (k + 1 <= 8));
        end
        RESET_n = 1'b0;
        per_oe  = 1'b1;
        #1;
        chk("midrst_CS_n", 32'(CS_n), 1);
        chk("midrst_IOWR_n", 32'(IOWR_n), 1);
        chk("midrst_IORD_n", 32'(IORD_n), 1);
        chk("midrst_D", 32'(D), 32'h3C);
        chk("midrst_A", 32'(A), 0);
        chk("midrst_D_read", 32'(D_read), 0);
        @(negedge clk);
        RESET_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_CS_n@%0d", k), 32'(CS_n), 1);
            chk($sformatf("post_rst_IOWR_n@%0d", k), 32'(IOWR_n), 1);
            chk($sformatf("post_rst_D@%0d", k), 32'(D), 32'h3C);
        end
        run_cycle(1'b1, 1'b0, 2'd2, 8'h00, 8'h5A, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
